div_core: RTL and testbench

Parametrised iterative integer divider: successor to the fixed 32-bit, 2-bit-per-cycle unsigned divider in the execute stage. It adds configurable operand width, a configurable retire rate of 1 or 2 quotient bits per cycle, and a signed/unsigned mode (MIPS DIV/DIVU). It also adds explicit divide-by-zero handling and a busy/done handshake with result hold while the writeback bus is occupied. It sits beside the multiplier and feeds HI/LO (R/Q).

---
 rtl/div_core.sv | 145 ++++++++++++++
 tb/tb_div_core.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_core.sv
`timescale 1ns/1ps
// div_core: iterative restoring integer divider, signed (DIV) or unsigned (DIVU),
// retiring RADIX_BITS quotient bits per cycle, with divide-by-zero reporting
// and a done/busbusy hold handshake.
module div_core #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic             is_busbusy,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             opreat_over,
  output logic             div_zero,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R
);

  localparam int          N  = WIDTH / RADIX_BITS;
  localparam int          CW = $clog2(N) + 1;
  localparam int unsigned RB = RADIX_BITS;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;     // {partial remainder, dividend/quotient}
  logic [WIDTH-1:0]   dvs_q, dvs_d;     // divisor magnitude
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               bzero_q, bzero_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic               dz_q, dz_d;

  logic [2*WIDTH-1:0] step;
  logic [WIDTH:0]     trial, diff;
  logic [WIDTH-1:0]   a_abs, b_abs, quo, rem;
  logic               accept;

  // RADIX_BITS chained shift/trial-subtract steps on the accumulator
  always_comb begin
    step  = acc_q;
    trial = '0;
    diff  = '0;
    for (int unsigned i = 0; i < RB; i++) begin
      trial = step[2*WIDTH-1:WIDTH-1];
      diff  = trial - {1'b0, dvs_q};
      if (diff[WIDTH]) step = {trial[WIDTH-1:0], step[WIDTH-2:0], 1'b0};
      else             step = {diff[WIDTH-1:0],  step[WIDTH-2:0], 1'b1};
    end
  end

  // Next-state, operand capture and result fix-up
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    bzero_d = bzero_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;

    a_abs  = (is_signed && A[WIDTH-1]) ? -A : A;
    b_abs  = (is_signed && B[WIDTH-1]) ? -B : B;
    quo    = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem    = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    accept = start && ((state_q == IDLE) || (state_q == DONE && !is_busbusy));

    case (state_q)
      IDLE: ;
      CALC: begin
        acc_d = step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) state_d = FIX;
      end
      FIX: begin
        if (bzero_q) begin
          q_d  = '1;
          r_d  = acc_q[WIDTH-1:0];
          dz_d = 1'b1;
        end else begin
          q_d  = quo;
          r_d  = rem;
          dz_d = 1'b0;
        end
        state_d = DONE;
      end
      DONE: if (!is_busbusy) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // On B == 0 the raw dividend is parked in the low half so FIX can return it as R
    if (accept) begin
      bzero_d = (B == '0);
      acc_d   = (B == '0) ? {{WIDTH{1'b0}}, A} : {{WIDTH{1'b0}}, a_abs};
      dvs_d   = b_abs;
      cnt_d   = '0;
      qneg_d  = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
      rneg_d  = is_signed & A[WIDTH-1];
      state_d = (B == '0) ? FIX : CALC;
    end
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      bzero_q <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      bzero_q <= bzero_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign busy        = (state_q == CALC) || (state_q == FIX);
  assign opreat_over = (state_q == DONE);
  assign div_zero    = dz_q;
  assign Q           = q_q;
  assign R           = r_q;

endmodule

// File: tb/tb_div_core.sv
`timescale 1ns/1ps
// tb_div_core: vector table and corner sequences on a 32-bit radix-4 divider,
// plus a randomised/boundary sweep on an 8-bit radix-2 instance against a model.
module tb_div_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, sgn, bb;
  logic [31:0] a, b, q, r;
  logic        busy, ov, dz;

  logic        start8, sgn8, bb8;
  logic [7:0]  a8, b8, q8, r8;
  logic        busy8, ov8, dz8;

  div_core #(.WIDTH(32), .RADIX_BITS(2)) dut32 (
    .clk(clk), .rst(rst), .start(start), .is_signed(sgn), .is_busbusy(bb),
    .A(a), .B(b), .busy(busy), .opreat_over(ov), .div_zero(dz), .Q(q), .R(r));

  div_core #(.WIDTH(8), .RADIX_BITS(1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .is_signed(sgn8), .is_busbusy(bb8),
    .A(a8), .B(b8), .busy(busy8), .opreat_over(ov8), .div_zero(dz8), .Q(q8), .R(r8));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a, b;
    logic        s;
    logic [31:0] q, r;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [31:0] q, r;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb32[$];
  exp_t sb8[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic exp_t ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
    exp_t e;
    int sx, sy, qi, ri;
    e.lat = (y == 8'd0) ? 1 : 9;
    if (y == 8'd0) begin
      e.q = 32'hFF; e.r = {24'd0, x}; e.dz = 1'b1;
      return e;
    end
    if (s) begin sx = int'($signed(x)); sy = int'($signed(y)); end
    else   begin sx = int'(x);          sy = int'(y);          end
    qi = sx / sy;
    ri = sx % sy;
    e.q = {24'd0, qi[7:0]}; e.r = {24'd0, ri[7:0]}; e.dz = 1'b0;
    return e;
  endfunction

  // Wait for completion (bounded), then pop the scoreboard and compare
  task automatic wait_done32(input string tag);
    int   n = 0;
    bit   busy_ok = 1'b1;
    exp_t e;
    while (!ov && n < 60) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    if (sb32.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb32.pop_front();
    chk({tag, "_latency"}, n, e.lat);
    chk({tag, "_busy_held"}, busy_ok, 1);
    chk({tag, "_busy_off"}, busy, 0);
    chk({tag, "_Q"}, q, e.q);
    chk({tag, "_R"}, r, e.r);
    chk({tag, "_dz"}, dz, e.dz);
  endtask

  task automatic op32(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                      input logic is, input exp_t e);
    @(negedge clk);
    a = ia; b = ib; sgn = is; start = 1'b1;
    sb32.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; sgn = ~sgn;
    chk({tag, "_busy_on"}, busy, 1);
    wait_done32(tag);
  endtask

  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic is);
    int   n = 0;
    exp_t e, g;
    @(negedge clk);
    a8 = ia; b8 = ib; sgn8 = is; start8 = 1'b1;
    sb8.push_back(ref8(ia, ib, is));
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    while (!ov8 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb8.pop_front();
    g.q = {24'd0, q8}; g.r = {24'd0, r8}; g.dz = dz8;
    if (g.q !== e.q || g.r !== e.r || g.dz !== e.dz || n != e.lat) begin
      $display("FAIL sweep8 a=%0h b=%0h s=%0d: got q=%0h r=%0h dz=%0d lat=%0d expected q=%0h r=%0h dz=%0d lat=%0d",
               ia, ib, is, g.q, g.r, g.dz, n, e.q, e.r, e.dz, e.lat);
      errors++;
    end
    checks++;
  endtask

  vec_t vecs[12];
  exp_t e;

  initial begin
    rst = 1'b0; start = 1'b0; sgn = 1'b0; bb = 1'b0; a = '0; b = '0;
    start8 = 1'b0; sgn8 = 1'b0; bb8 = 1'b0; a8 = '0; b8 = '0;

    vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
    vecs[1]  = '{32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    vecs[2]  = '{32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          1'b0};
    vecs[3]  = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0};
    vecs[4]  = '{32'h1234,       32'd0,          1'b0, 32'hFFFFFFFF,   32'h1234,       1'b1};
    vecs[5]  = '{32'h1234,       32'd0,          1'b1, 32'hFFFFFFFF,   32'h1234,       1'b1};
    vecs[6]  = '{32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          1'b0};
    vecs[7]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'd1,          32'd0,          1'b0};
    vecs[8]  = '{32'd5,          32'd9,          1'b0, 32'd0,          32'd5,          1'b0};
    vecs[9]  = '{32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, 32'd14,         32'hFFFFFFFE,   1'b0};
    vecs[10] = '{32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000,   1'b0};
    vecs[11] = '{32'hFFFFFFF0,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFF0,   1'b1};

    #12;
    chk("reset_busy", busy, 0);
    chk("reset_ov", ov, 0);
    chk("reset_dz", dz, 0);
    chk("reset_Q", q, 0);
    chk("reset_R", r, 0);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      e.q = vecs[i].q; e.r = vecs[i].r; e.dz = vecs[i].dz;
      e.lat = (vecs[i].b == 32'd0) ? 1 : 17;
      op32($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, e);
    end

    // results persist through IDLE
    repeat (3) @(posedge clk);
    #1;
    chk("idle_ov", ov, 0);
    chk("idle_hold_Q", q, 32'hFFFFFFFF);
    chk("idle_hold_R", r, 32'hFFFFFFF0);
    chk("idle_hold_dz", dz, 1);

    // stall in DONE with start pulses, then back-to-back accept
    e = '{32'd14, 32'd2, 1'b0, 17};
    op32("stall_pre", 32'd100, 32'd7, 1'b0, e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bb = 1'b1; start = (i % 2 == 0); a = 32'd1; b = 32'd1; sgn = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("stall%0d_ov", i), ov, 1);
      chk($sformatf("stall%0d_busy", i), busy, 0);
      chk($sformatf("stall%0d_Q", i), q, 14);
      chk($sformatf("stall%0d_R", i), r, 2);
    end
    @(negedge clk);
    bb = 1'b0; start = 1'b1; a = 32'd9; b = 32'd3; sgn = 1'b0;
    sb32.push_back('{32'd3, 32'd0, 1'b0, 17});
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy_on", busy, 1);
    chk("b2b_ov_off", ov, 0);
    wait_done32("b2b");

    // asynchronous reset during iteration 8
    @(negedge clk);
    a = 32'd1000; b = 32'd3; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ov", ov, 0);
    chk("midrst_dz", dz, 0);
    chk("midrst_Q", q, 0);
    chk("midrst_R", r, 0);
    @(negedge clk); rst = 1'b1;
    e = '{32'd10, 32'd0, 1'b0, 17};
    op32("post_rst", 32'd50, 32'd5, 1'b0, e);

    // 8-bit radix-2 sweep: boundary pairs then random operands, both modes
    for (int m = 0; m < 2; m++) begin
      logic [7:0] ba [8];
      logic [7:0] bbv[8];
      ba  = '{8'h80, 8'h7F, 8'h00, 8'hFF, 8'hFF, 8'h80, 8'h01, 8'h81};
      bbv = '{8'hFF, 8'h80, 8'h00, 8'h00, 8'h01, 8'h01, 8'hFF, 8'h7F};
      for (int i = 0; i < 8; i++) op8(ba[i], bbv[i], m[0]);
      for (int i = 0; i < 600; i++) begin
        logic [7:0] ra, rb;
        ra = 8'($urandom);
        rb = (i % 16 == 0) ? 8'd0 : 8'($urandom);
        op8(ra, rb, m[0]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
